// File: rtl/led_blinker_pkg.sv
// rtl/led_blinker_pkg.sv - shared types and helpers for the LED blinker
//
// Purpose: FSM state encoding and timer sizing shared by led_blinker and
//          blink_timer.
// Contents:
//   blink_state_t       - IDLE / ON / GAP blink states
//   timer_width()       - bits needed to count 0..max(on,off)-1 (at least 1)
package led_blinker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } blink_state_t;

    // A single shared timer serves both phases, so size it for the longer one.
    // A one-cycle phase still needs a 1-bit counter to hold the value 0.
    function automatic int timer_width(input int on_clocks, input int off_clocks);
        int longest;
        longest = (on_clocks > off_clocks) ? on_clocks : off_clocks;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - phase timer shared by the ON and GAP states
//
// Purpose: up-counter with synchronous clear that stops at a caller-supplied
//          terminal count and flags it.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset
//   clr_i    in  synchronous clear (load 0), has priority over counting
//   en_i     in  count enable
//   tc_i     in  terminal count value (phase length - 1)
//   done_o   out high while enabled and the count equals tc_i
module blink_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] tc_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Holding at the terminal count keeps the counter from ever wrapping,
    // even if the owner lingers in a phase for an extra cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != tc_i)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == tc_i);

endmodule

// File: rtl/led_blinker.sv
// rtl/led_blinker.sv - turns event pulses/levels into visible LED blinks
//
// Purpose: each rising edge of evt_i produces one blink of ON_CLOCKS cycles
//          followed by a dark gap of OFF_CLOCKS cycles. Events arriving during
//          a blink are queued in a saturating counter and replayed.
// Build option: define LED_BLINKER_ACTIVE_LOW_EN for an active-low led_o.
// Ports:
//   clk         in  clock, rising edge
//   rst         in  asynchronous active-high reset
//   evt_i       in  event request, each 0->1 transition is one event
//   clr_ovf_i   in  synchronous clear of overflow_o (a same-edge set wins)
//   led_o       out LED drive
//   busy_o      out high while blinking or in the dark gap
//   pending_o   out number of queued events not yet shown
//   overflow_o  out sticky, set when an event is dropped at saturation
module led_blinker
    import led_blinker_pkg::*;
#(
    parameter int ON_CLOCKS   = 25_000_000,
    parameter int OFF_CLOCKS  = 25_000_000,
    parameter int MAX_PENDING = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               evt_i,
    input  logic                               clr_ovf_i,
    output logic                               led_o,
    output logic                               busy_o,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_o,
    output logic                               overflow_o
);

    localparam int TW = timer_width(ON_CLOCKS, OFF_CLOCKS);
    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [TW-1:0] ON_TC    = TW'(ON_CLOCKS - 1);
    localparam logic [TW-1:0] OFF_TC   = TW'(OFF_CLOCKS - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    blink_state_t  state_q, state_d;
    logic          evt_q;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;

    logic          rise;
    logic          pend_nz;
    logic          inc;
    logic          dec;
    logic          timer_clr;
    logic          timer_en;
    logic [TW-1:0] timer_tc;
    logic          timer_done;

    assign rise    = evt_i & ~evt_q;
    assign pend_nz = (pend_q != '0);

    blink_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .tc_i   (timer_tc),
        .done_o (timer_done)
    );

    assign timer_en  = (state_q == ST_ON) || (state_q == ST_GAP);
    assign timer_tc  = (state_q == ST_ON) ? ON_TC : OFF_TC;
    // Every transition is a state entry, and every entry restarts the timer.
    assign timer_clr = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A queued event (left by a rise on the GAP->IDLE edge) is
                // served first; otherwise a fresh rise starts a blink directly.
                if (pend_nz) begin
                    state_d = ST_ON;
                    dec     = 1'b1;
                end else if (rise) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (timer_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_done) begin
                    if (pend_nz) begin
                        state_d = ST_ON;
                        dec     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A rise is queued unless it starts a blink straight from an empty IDLE.
        inc = rise && ((state_q != ST_IDLE) || pend_nz);

        // A simultaneous queue and dequeue cancel out, so nothing is dropped
        // even when the counter sits at saturation.
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (inc && !dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PW'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PW'(1);
        end

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            evt_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_i;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

`ifdef LED_BLINKER_ACTIVE_LOW_EN
    assign led_o = ~led_q;
`else
    assign led_o = led_q;
`endif

    assign busy_o     = busy_q;
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_led_blinker.sv
// tb/tb_led_blinker.sv - directed scoreboard bench for led_blinker
module tb_led_blinker;

    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int MAXP  = 2;

`ifdef LED_BLINKER_ACTIVE_LOW_EN
    localparam logic [1:0] L_ON  = 2'd0;
    localparam logic [1:0] L_OFF = 2'd1;
`else
    localparam logic [1:0] L_ON  = 2'd1;
    localparam logic [1:0] L_OFF = 2'd0;
`endif

    localparam int S_LED  = 0;
    localparam int S_BUSY = 1;
    localparam int S_PEND = 2;
    localparam int S_OVF  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt = 1'b0;
    logic       clr = 1'b0;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;

    led_blinker #(
        .ON_CLOCKS   (ON_C),
        .OFF_CLOCKS  (OFF_C),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_i      (evt),
        .clr_ovf_i  (clr),
        .led_o      (led),
        .busy_o     (busy),
        .pending_o  (pend),
        .overflow_o (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      tag;
        int         sig;
        logic [1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic finish_req = 1'b0;
    logic final_done = 1'b0;

    function automatic logic [1:0] observe(input int sig);
        case (sig)
            S_LED:   return {1'b0, led};
            S_BUSY:  return {1'b0, busy};
            S_PEND:  return pend;
            default: return {1'b0, ovf};
        endcase
    endfunction

    // Expectations are stamped with the cycle they refer to and compared on
    // the falling edge of that cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                logic [1:0] o;
                o = observe(sb[i].sig);
                n_checks++;
                assert (o === sb[i].val) n_pass++;
                else $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                            sb[i].tag, cyc, o, sb[i].val);
                sb.delete(i);
            end
        end
        if (finish_req && !final_done) begin
            n_checks++;
            assert (sb.size() == 0) n_pass++;
            else $error("FAIL sb_drained observed=%0d expected=0", sb.size());
            final_done = 1'b1;
        end
    end

    task automatic expect_at(input int at, input string tag, input int sig,
                             input logic [1:0] val);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    // Stimulus always changes 1 time unit after a rising edge.
    task automatic wait_until(input int at);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int at);
        wait_until(at);
        evt = 1'b1;
        wait_until(at + 1);
        evt = 1'b0;
    endtask

    int c;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        c = cyc;
        expect_at(c, "rst_led",  S_LED,  L_OFF);
        expect_at(c, "rst_busy", S_BUSY, 2'd0);
        expect_at(c, "rst_pend", S_PEND, 2'd0);
        expect_at(c, "rst_ovf",  S_OVF,  2'd0);
        wait_until(c + 1);
        rst = 1'b0;
        wait_until(c + 3);

        // Single one-cycle pulse
        c = cyc + 1;
        expect_at(c, "single_pre_led", S_LED, L_OFF);
        for (int k = 1; k <= 4; k++) expect_at(c + k, "single_on", S_LED, L_ON);
        expect_at(c + 5, "single_off",       S_LED,  L_OFF);
        expect_at(c + 7, "single_gap_led",   S_LED,  L_OFF);
        expect_at(c + 1, "single_busy_up",   S_BUSY, 2'd1);
        expect_at(c + 7, "single_busy_gap",  S_BUSY, 2'd1);
        expect_at(c + 8, "single_busy_down", S_BUSY, 2'd0);
        expect_at(c + 3, "single_pend",      S_PEND, 2'd0);
        pulse(c);
        wait_until(c + 10);

        // Held level: one blink only
        c = cyc + 1;
        expect_at(c + 1,  "held_on1",   S_LED,  L_ON);
        expect_at(c + 4,  "held_on4",   S_LED,  L_ON);
        expect_at(c + 5,  "held_off5",  S_LED,  L_OFF);
        expect_at(c + 10, "held_off10", S_LED,  L_OFF);
        expect_at(c + 15, "held_off15", S_LED,  L_OFF);
        expect_at(c + 21, "held_off21", S_LED,  L_OFF);
        expect_at(c + 24, "held_off24", S_LED,  L_OFF);
        expect_at(c + 9,  "held_busy9", S_BUSY, 2'd0);
        expect_at(c + 20, "held_busy20", S_BUSY, 2'd0);
        expect_at(c + 10, "held_pend",  S_PEND, 2'd0);
        wait_until(c);
        evt = 1'b1;
        wait_until(c + 20);
        evt = 1'b0;
        wait_until(c + 26);

        // Queueing: three pulses, blinks with a 7-cycle period
        c = cyc + 1;
        expect_at(c + 3,  "q_pend1",     S_PEND, 2'd1);
        expect_at(c + 5,  "q_pend2",     S_PEND, 2'd2);
        expect_at(c + 6,  "q_ovf",       S_OVF,  2'd0);
        expect_at(c + 7,  "q_gap_led",   S_LED,  L_OFF);
        expect_at(c + 8,  "q_b2_led",    S_LED,  L_ON);
        expect_at(c + 8,  "q_b2_pend",   S_PEND, 2'd1);
        expect_at(c + 14, "q_gap2_led",  S_LED,  L_OFF);
        expect_at(c + 15, "q_b3_led",    S_LED,  L_ON);
        expect_at(c + 15, "q_b3_pend",   S_PEND, 2'd0);
        expect_at(c + 18, "q_b3_end",    S_LED,  L_ON);
        expect_at(c + 19, "q_b3_off",    S_LED,  L_OFF);
        expect_at(c + 21, "q_busy_gap",  S_BUSY, 2'd1);
        expect_at(c + 22, "q_busy_idle", S_BUSY, 2'd0);
        expect_at(c + 22, "q_ovf_end",   S_OVF,  2'd0);
        pulse(c);
        pulse(c + 2);
        pulse(c + 4);
        wait_until(c + 24);

        // Overflow, clear, and clear colliding with a dropped rise
        c = cyc + 1;
        expect_at(c + 5,  "o_pend_sat",   S_PEND, 2'd2);
        expect_at(c + 6,  "o_ovf_pre",    S_OVF,  2'd0);
        expect_at(c + 7,  "o_pend_hold",  S_PEND, 2'd2);
        expect_at(c + 7,  "o_ovf_set",    S_OVF,  2'd1);
        expect_at(c + 9,  "o_ovf_sticky", S_OVF,  2'd1);
        expect_at(c + 10, "o_ovf_clr",    S_OVF,  2'd0);
        expect_at(c + 11, "o_pend_re",    S_PEND, 2'd2);
        expect_at(c + 12, "o_ovf_still0", S_OVF,  2'd0);
        expect_at(c + 13, "o_set_wins",   S_OVF,  2'd1);
        expect_at(c + 13, "o_pend_drop",  S_PEND, 2'd2);
        expect_at(c + 22, "o_b4_led",     S_LED,  L_ON);
        expect_at(c + 29, "o_busy_idle",  S_BUSY, 2'd0);
        expect_at(c + 29, "o_ovf_kept",   S_OVF,  2'd1);
        expect_at(c + 31, "o_ovf_clr2",   S_OVF,  2'd0);
        pulse(c);
        pulse(c + 2);
        pulse(c + 4);
        pulse(c + 6);
        wait_until(c + 9);
        clr = 1'b1;
        wait_until(c + 10);
        clr = 1'b0;
        pulse(c + 10);
        wait_until(c + 12);
        evt = 1'b1;
        clr = 1'b1;
        wait_until(c + 13);
        evt = 1'b0;
        clr = 1'b0;
        wait_until(c + 30);
        clr = 1'b1;
        wait_until(c + 31);
        clr = 1'b0;
        wait_until(c + 33);

        // Rise on the GAP terminal edge while saturated
        c = cyc + 1;
        expect_at(c + 5,  "ba_pend_sat",  S_PEND, 2'd2);
        expect_at(c + 8,  "ba_pend_keep", S_PEND, 2'd2);
        expect_at(c + 8,  "ba_ovf_none",  S_OVF,  2'd0);
        expect_at(c + 8,  "ba_led",       S_LED,  L_ON);
        expect_at(c + 15, "ba_pend1",     S_PEND, 2'd1);
        expect_at(c + 22, "ba_pend0",     S_PEND, 2'd0);
        expect_at(c + 29, "ba_busy_idle", S_BUSY, 2'd0);
        expect_at(c + 29, "ba_ovf_end",   S_OVF,  2'd0);
        pulse(c);
        pulse(c + 2);
        pulse(c + 4);
        pulse(c + 7);
        wait_until(c + 31);

        // Rise on the GAP->IDLE edge
        c = cyc + 1;
        expect_at(c + 7,  "bb_busy_gap",  S_BUSY, 2'd1);
        expect_at(c + 8,  "bb_busy_idle", S_BUSY, 2'd0);
        expect_at(c + 8,  "bb_pend1",     S_PEND, 2'd1);
        expect_at(c + 8,  "bb_led_idle",  S_LED,  L_OFF);
        expect_at(c + 9,  "bb_led_on",    S_LED,  L_ON);
        expect_at(c + 9,  "bb_pend0",     S_PEND, 2'd0);
        expect_at(c + 12, "bb_led_end",   S_LED,  L_ON);
        expect_at(c + 13, "bb_led_off",   S_LED,  L_OFF);
        expect_at(c + 15, "bb_busy_gap2", S_BUSY, 2'd1);
        expect_at(c + 16, "bb_busy_done", S_BUSY, 2'd0);
        expect_at(c + 18, "bb_no_more1",  S_LED,  L_OFF);
        expect_at(c + 22, "bb_no_more2",  S_LED,  L_OFF);
        expect_at(c + 22, "bb_pend_end",  S_PEND, 2'd0);
        pulse(c);
        pulse(c + 7);
        wait_until(c + 24);

        // Reset mid-ON with a queued event and overflow set
        c = cyc + 1;
        expect_at(c + 8,  "r_pre_led",   S_LED,  L_ON);
        expect_at(c + 8,  "r_pre_pend",  S_PEND, 2'd1);
        expect_at(c + 8,  "r_pre_ovf",   S_OVF,  2'd1);
        expect_at(c + 9,  "r_led",       S_LED,  L_OFF);
        expect_at(c + 9,  "r_busy",      S_BUSY, 2'd0);
        expect_at(c + 9,  "r_pend",      S_PEND, 2'd0);
        expect_at(c + 9,  "r_ovf",       S_OVF,  2'd0);
        expect_at(c + 12, "r_post_led1", S_LED,  L_OFF);
        expect_at(c + 15, "r_post_led2", S_LED,  L_OFF);
        expect_at(c + 20, "r_post_led3", S_LED,  L_OFF);
        expect_at(c + 14, "r_post_busy", S_BUSY, 2'd0);
        expect_at(c + 14, "r_post_pend", S_PEND, 2'd0);
        expect_at(c + 14, "r_post_ovf",  S_OVF,  2'd0);
        pulse(c);
        pulse(c + 2);
        pulse(c + 4);
        pulse(c + 6);
        wait_until(c + 9);
        rst = 1'b1;
        wait_until(c + 11);
        rst = 1'b0;
        wait_until(c + 22);

        finish_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_blinker.md
# led_blinker

Output-side indicator conditioner: turns short internal event pulses or levels into human-visible LED blinks, each with a guaranteed minimum on-time and off-gap. Events that arrive while a blink is in progress are queued in a saturating pending counter and replayed as separate blinks. It sits between status logic (for example a debounced button level) and a board LED pin.

## Interface
- `ON_CLOCKS`, default 25_000_000: LED on-time per blink, in clk cycles; must be ≥1.
- `OFF_CLOCKS`, default 25_000_000: forced dark gap after each blink, in clk cycles; must be ≥1.
- `MAX_PENDING`, default 7: capacity of the pending-event counter; must be ≥1.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `evt_i` in 1: event request. Each 0→1 transition counts as one event.
- `clr_ovf_i` in 1: synchronous clear of `overflow_o`.
- `led_o` out 1: LED drive. Active-high unless the polarity macro is defined.
- `busy_o` out 1: high in the ON or GAP state.
- `pending_o` out $clog2(MAX_PENDING+1): number of queued events not yet shown.
- `overflow_o` out 1: sticky flag; set when an event is dropped.

## Operation
- Edge detect:
  - `evt_q` is the registered `evt_i`; its reset value is 0.
  - `rise = evt_i & ~evt_q`.
  - A level held high counts once. If `evt_i` is high when reset releases, that counts as one event.
- FSM has three states: IDLE, ON, GAP. Reset state is IDLE.
  - IDLE: on `rise`, go to ON and clear the timer.
  - ON: the timer counts 0..ON_CLOCKS-1. At terminal count, go to GAP and clear the timer.
  - GAP: the timer counts 0..OFF_CLOCKS-1. At terminal count:
    - if `pending_o` > 0, decrement it and go to ON;
    - otherwise go to IDLE.
- Pending counter:
  - A `rise` while in ON or GAP increments the counter, saturating at MAX_PENDING.
  - A `rise` at saturation leaves the counter at MAX_PENDING and sets `overflow_o`.
- Simultaneous events:
  - `rise` on the same edge as the GAP→ON decrement leaves the count unchanged. This holds even at MAX_PENDING, and no overflow is raised.
  - `rise` on the GAP→IDLE edge increments the counter to 1, and the next state is IDLE. On the following cycle the FSM leaves IDLE because `pending_o` ≠ 0: it decrements the counter and goes to ON. No event is lost.
  - `rise` in IDLE with `pending_o` = 0 goes straight to ON; the counter does not change.
- Overflow flag:
  - `clr_ovf_i` clears `overflow_o`.
  - If a clear and a set occur on the same edge, set wins.
- Timer width is $clog2(max(ON_CLOCKS,OFF_CLOCKS)). The timer never wraps; it is cleared on every state entry.
- Reset mid-blink: `led_o` goes to its inactive level immediately (asynchronous). All counters go to 0, the FSM goes to IDLE, and queued events are discarded.

## Timing
- Reset values:
  - `led_o` at its inactive level;
  - `busy_o` = 0;
  - `pending_o` = 0;
  - `overflow_o` = 0.
- All outputs are registered; none has a combinational path from an input.
- Latency: with `evt_i` rising before edge t in IDLE, `led_o` is active from just after edge t.
- `led_o` is active for exactly ON_CLOCKS cycles, then inactive for at least OFF_CLOCKS cycles.
- Back-to-back queued blinks: period = ON_CLOCKS + OFF_CLOCKS cycles.
- `busy_o` tracks the registered state: it asserts on the same edge as `led_o` and drops on the GAP→IDLE edge.
- `pending_o` and `overflow_o` update on the edge that samples the `rise`.

## Configuration
- Macro `LED_BLINKER_ACTIVE_LOW_EN`:
  - Defined: `led_o` is inverted. Its inactive and reset level is 1, and it is driven 0 while ON.
  - Undefined: `led_o` is 1 while ON and 0 otherwise, including reset.
- Only the output polarity changes; FSM, counters and all other outputs are identical in both builds.

## Structure
- `led_blinker_pkg` holds:
  - the state enum `blink_state_t` (IDLE, ON, GAP);
  - a localparam function for the timer width.
- One sub-module, `blink_timer`:
  - a loadable up-counter with synchronous clear, asynchronous reset and a terminal-count output;
  - the terminal count is a port input so ON and GAP share one instance.
- Pending counter, edge detect and FSM live in `led_blinker`.

## Test plan
Use ON_CLOCKS=4, OFF_CLOCKS=3, MAX_PENDING=2 throughout.
- Single event: one-cycle `evt_i` pulse in IDLE → `led_o` high for exactly 4 cycles starting 1 cycle later, then low; `busy_o` high for 7 cycles; `pending_o` stays 0.
- Held level: `evt_i` high for 20 cycles → exactly one blink.
- Queueing: 3 pulses within the first ON phase → `pending_o` goes 1 then 2, no overflow, three blinks with a 7-cycle period; `pending_o` reads 0 after the last blink starts.
- Overflow: 4 pulses during one blink → `pending_o` saturates at 2, `overflow_o` = 1 and stays set. `clr_ovf_i` pulse → 0; `clr_ovf_i` together with a dropping `rise` → stays 1.
- Boundary: a `rise` on the GAP terminal edge with `pending_o` = 2 → `pending_o` stays 2, no overflow. A `rise` on the GAP→IDLE edge → exactly one further blink, starting 1 cycle later.
- Reset: assert `rst` mid-ON with `pending_o` = 1 → `led_o` inactive immediately, all outputs at reset values, no blink after release. Repeat the build with `LED_BLINKER_ACTIVE_LOW_EN` defined and check the inverted `led_o` levels.
